// File: rtl/cpu_step_sequencer.sv
// cpu_step_sequencer: one-hot control-step generator with early done, hold and instruction counter
module cpu_step_sequencer #(
  parameter int NSTEPS = 4,
  parameter int CW = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              run,
  input  logic              done,
  input  logic              hold,
  output logic [NSTEPS-1:0] step,
  output logic [2:0]        step_idx,
  output logic              busy,
  output logic              ir_load,
  output logic              fin,
  output logic [CW-1:0]     instr_count
);
  typedef enum logic {IDLE, EXEC} state_t;
  state_t state, state_nx;
  logic [2:0] idx_nx;
  logic complete;
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      state <= IDLE;
      step_idx <= '0;
      fin <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= state_nx;
      step_idx <= idx_nx;
      fin <= complete;
      instr_count <= instr_count + {{(CW-1){1'b0}}, complete};
    end
  // hold outranks both done and the natural last step
  always_comb begin
    complete = state == EXEC && !hold && (done || step_idx == 3'(NSTEPS-1));
    state_nx = state == IDLE ? (run ? EXEC : IDLE) : (complete && !run ? IDLE : EXEC);
    idx_nx = state == IDLE || complete ? 3'd0 : hold ? step_idx : step_idx + 3'd1;
  end
  always_comb begin
    busy = state == EXEC;
    step = busy ? {{(NSTEPS-1){1'b0}}, 1'b1} << step_idx : '0;
    ir_load = busy && step_idx == 3'd0;
  end
endmodule

// File: tb/tb_cpu_step_sequencer.sv
// tb_cpu_step_sequencer: randomized and directed stimulus checked against an instruction-level model
module tb_cpu_step_sequencer;
  localparam int N = 4;
  localparam int CW = 4;
  logic clk = 1'b0, clr = 1'b1, run = 1'b0, done = 1'b0, hold = 1'b0;
  logic [N-1:0] step;
  logic [2:0] step_idx;
  logic busy, ir_load, fin;
  logic [CW-1:0] instr_count;
  int checks = 0, fails = 0;
  int cur = -1, cnt = 0, m_fin = 0;

  cpu_step_sequencer #(.NSTEPS(N), .CW(CW)) dut (
    .clk(clk), .clr(clr), .run(run), .done(done), .hold(hold),
    .step(step), .step_idx(step_idx), .busy(busy), .ir_load(ir_load),
    .fin(fin), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("step", 32'(step), cur < 0 ? 0 : 32'(1) << cur);
    check("step_idx", 32'(step_idx), cur < 0 ? 0 : cur);
    check("busy", 32'(busy), 32'(cur >= 0));
    check("ir_load", 32'(ir_load), 32'(cur == 0));
    check("fin", 32'(fin), m_fin);
    check("instr_count", 32'(instr_count), cnt);
  endtask

  // model: cur is the current step number, -1 when idle
  task automatic cycle(input logic r, input logic d, input logic h);
    run = r; done = d; hold = h;
    @(posedge clk);
    m_fin = 0;
    if (cur < 0) begin
      if (r) cur = 0;
    end else if (!h) begin
      if (d || cur == N - 1) begin
        m_fin = 1;
        cnt = (cnt + 1) % (1 << CW);
        cur = r ? 0 : -1;
      end else cur++;
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic pulse_clr();
    #2 clr = 1'b1;
    #1 cur = -1; cnt = 0; m_fin = 0;
    check_all();
    #1 clr = 1'b0;
  endtask

  initial begin
    #2 check_all();
    @(negedge clk) clr = 1'b0;
    // full instruction
    cycle(1, 0, 0);
    repeat (4) cycle(0, 0, 0);
    // early done in T1
    cycle(1, 0, 0); cycle(0, 0, 0); cycle(0, 1, 0); cycle(0, 0, 0);
    // hold in T2 with an ignored done
    cycle(1, 0, 0); cycle(0, 0, 0); cycle(0, 0, 0);
    cycle(0, 1, 1); cycle(0, 0, 1); cycle(0, 0, 0); cycle(0, 0, 0); cycle(0, 0, 0);
    // back-to-back
    repeat (12) cycle(1, 0, 0);
    cycle(0, 0, 0);
    check("b2b_count", 32'(instr_count), 32'((cnt) % 16));
    // async clear at T2
    cycle(1, 0, 0); cycle(0, 0, 0); cycle(0, 0, 0);
    pulse_clr();
    cycle(0, 0, 0);
    // wrap: 17 instructions from zero
    repeat (17 * N) cycle(1, 0, 0);
    cycle(0, 0, 0);
    check("wrap_count", 32'(instr_count), 32'd1);
    // random
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) pulse_clr();
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) < 15),
            1'($urandom_range(0, 99) < 20));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
